// File: rtl/rf_write_arbiter_if.sv
// Bundle for the write-port arbiter: two writeback requesters, the register-file
// write port, the decode hazard query and the collision flag.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rd_add_1;
    logic [ADDR_W-1:0] rd_add_2;
    logic              hazard_1;
    logic              hazard_2;
    logic              collision;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output rd_add_1, rd_add_2,
        input  a_ready, b_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  hazard_1, hazard_2, collision
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  rd_add_1, rd_add_2,
        output a_ready, b_ready,
        output rf_we, rf_waddr, rf_wdata,
        output hazard_1, hazard_2, collision
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU and load
// writeback, with per-source queues, decode hazard flags and a sticky collision flag.
module rf_write_arbiter_queue #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    input  logic [ADDR_W-1:0] q3_addr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              q1_hit,
    output logic              q2_hit,
    output logic              q3_hit
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  count;
    logic [FIFO_DEPTH-1:0] slot_vld;

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == PTR_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign head_addr = mem_addr[rd_ptr[IDX_W-1:0]];
    assign head_data = mem_data[rd_ptr[IDX_W-1:0]];

    // A slot holds a live entry when its distance from the head is below the fill count.
    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_slot
        logic [IDX_W-1:0] slot_off;
        assign slot_off    = IDX_W'(g) - rd_ptr[IDX_W-1:0];
        assign slot_vld[g] = ({1'b0, slot_off} < count);
    end

    always_comb begin
        q1_hit = 1'b0;
        q2_hit = 1'b0;
        q3_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_vld[i] && (mem_addr[i] == q1_addr)) q1_hit = 1'b1;
            if (slot_vld[i] && (mem_addr[i] == q2_addr)) q2_hit = 1'b1;
            if (slot_vld[i] && (mem_addr[i] == q3_addr)) q3_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr[IDX_W-1:0]] <= push_addr;
            mem_data[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end
endmodule

module rf_write_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);
    logic              a_full, a_empty, b_full, b_empty;
    logic              push_a, push_b, grant_a, grant_b;
    logic [ADDR_W-1:0] a_head_addr, b_head_addr;
    logic [DATA_W-1:0] a_head_data, b_head_data;
    logic              a_hit_1, a_hit_2, a_hit_b;
    logic              b_hit_1, b_hit_2, b_hit_a;
    logic              rr_b_next;

    rf_write_arbiter_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_queue_a (
        .clk(clk), .reset(reset),
        .push(push_a), .push_addr(bus.a_addr), .push_data(bus.a_data),
        .pop(grant_a),
        .q1_addr(bus.rd_add_1), .q2_addr(bus.rd_add_2), .q3_addr(bus.b_addr),
        .full(a_full), .empty(a_empty),
        .head_addr(a_head_addr), .head_data(a_head_data),
        .q1_hit(a_hit_1), .q2_hit(a_hit_2), .q3_hit(a_hit_b)
    );

    rf_write_arbiter_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_queue_b (
        .clk(clk), .reset(reset),
        .push(push_b), .push_addr(bus.b_addr), .push_data(bus.b_data),
        .pop(grant_b),
        .q1_addr(bus.rd_add_1), .q2_addr(bus.rd_add_2), .q3_addr(bus.a_addr),
        .full(b_full), .empty(b_empty),
        .head_addr(b_head_addr), .head_data(b_head_data),
        .q1_hit(b_hit_1), .q2_hit(b_hit_2), .q3_hit(b_hit_a)
    );

    // Ready looks at full only, so a full queue never accepts even while draining.
    assign bus.a_ready = ~a_full;
    assign bus.b_ready = ~b_full;
    assign push_a      = bus.a_valid & ~a_full;
    assign push_b      = bus.b_valid & ~b_full;

    assign grant_a = ~a_empty & (b_empty | ~rr_b_next);
    assign grant_b = ~b_empty & ~grant_a;

    assign bus.hazard_1 = a_hit_1 | b_hit_1 | (bus.rf_we & (bus.rf_waddr == bus.rd_add_1));
    assign bus.hazard_2 = a_hit_2 | b_hit_2 | (bus.rf_we & (bus.rf_waddr == bus.rd_add_2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rf_we     <= 1'b0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.collision <= 1'b0;
            rr_b_next     <= 1'b0;
        end else begin
            bus.rf_we <= grant_a | grant_b;
            if (grant_a) begin
                bus.rf_waddr <= a_head_addr;
                bus.rf_wdata <= a_head_data;
            end else if (grant_b) begin
                bus.rf_waddr <= b_head_addr;
                bus.rf_wdata <= b_head_data;
            end
            // Pointer only moves when both sources actually contend.
            if (~a_empty & ~b_empty) rr_b_next <= grant_a;
            if ((push_a & b_hit_a) | (push_b & a_hit_b) |
                (push_a & push_b & (bus.a_addr == bus.b_addr)))
                bus.collision <= 1'b1;
        end
    end
endmodule
